mem_access_unit: RTL
====================

// Module: mem_access_unit
//
// PURPOSE
//   Load/store front end sitting directly upstream of the data memory.
//   - Accepts one core request at a time over a valid/ready handshake.
//   - Sequences the memory's single address/write port.
//   - Returns load data, or status, over a valid/ready response channel.
//   - Optionally performs atomic read-modify-write add (fetch-and-add).
//
// PARAMETERS
//   DATA_SIZE  8  data word width; must match the data memory
//   ADDR_SIZE  5  address width; must match the data memory (2**ADDR_SIZE words)
//
// PORTS
//   clk          in   1          single clock; all logic on posedge
//   rst          in   1          synchronous, active-high reset
//   req_valid    in   1          core request valid
//   req_ready    out  1          unit can accept a request
//   req_op       in   2          00 load, 01 store, 10 fetch-add, 11 reserved
//   req_addr     in   ADDR_SIZE  word address
//   req_wdata    in   DATA_SIZE  store data / fetch-add addend
//   rsp_valid    out  1          response valid
//   rsp_ready    in   1          core accepts response
//   rsp_rdata    out  DATA_SIZE  load data / old value (fetch-add); 0 for store or error
//   rsp_err      out  1          request had an unsupported op
//   mem_W        out  1          memory write enable
//   mem_DATA_WR  out  DATA_SIZE  memory write data
//   mem_ADDR     out  ADDR_SIZE  memory address (registered)
//   mem_DATA_RD  in   DATA_SIZE  memory read data; combinational from mem_ADDR
//
// BEHAVIOUR
//   Reset
//   - Synchronous; rst high at a posedge forces state IDLE.
//   - Clears: rsp_valid, rsp_rdata, rsp_err, mem_W, mem_DATA_WR, mem_ADDR, latched op/wdata.
//   - Abandons any in-flight request; no write completes.
//   - req_ready = 0 and mem_W = 0 while rst is high (both gated by !rst).
//   FSM states: IDLE, ACCESS, RMW_WR, RESP
//   IDLE
//   - req_ready = 1.
//   - On req_valid & req_ready: latch op and wdata, load mem_ADDR <= req_addr, go to ACCESS.
//   - Reserved op: latch, set rsp_err = 1, rsp_rdata = 0, go directly to RESP.
//   ACCESS (1 cycle)
//   - Load: rsp_rdata <= mem_DATA_RD; go to RESP.
//   - Store: mem_W = 1 with mem_DATA_WR = wdata for exactly this cycle; rsp_rdata <= 0; go to RESP.
//   - Fetch-add: rsp_rdata <= mem_DATA_RD; go to RMW_WR.
//   RMW_WR (1 cycle)
//   - mem_W = 1; mem_DATA_WR = rsp_rdata + wdata, truncated mod 2**DATA_SIZE (no carry out).
//   - Go to RESP.
//   RESP
//   - rsp_valid = 1, with rsp_rdata and rsp_err held stable until rsp_ready.
//   - On rsp_valid & rsp_ready: clear rsp_valid and rsp_err; go to IDLE.
//   Handshake and latency
//   - req_ready = 0 in every state except IDLE; no pipelining.
//   - rsp_valid rises 2 cycles after acceptance for load/store, 3 for fetch-add, 1 for error.
//   - Back-to-back request accepted at the earliest 1 cycle after the response handshake.
//   Boundary conditions
//   - mem_W is never high outside ACCESS (store) or RMW_WR.
//   - mem_ADDR holds the last accessed address while IDLE.
//   - Address wrap is not applicable: every req_addr value is valid.
//   - A store then a load to the same address returns the new data.
//   - Fetch-add overflow wraps, e.g. 8'hFF + 8'h02 writes 8'h01 and returns 8'hFF.
//
// CONFIGURATION
//   MEM_ACCESS_UNIT_RMW_EN
//   - Defined: op 10 performs fetch-add as described above.
//   - Undefined: RMW_WR state and adder are removed; op 10 is treated exactly as reserved
//     (rsp_err = 1, no memory access).
//
// TESTING
//   1. Store addr 5 data 8'hA5, then load addr 5 -> store rsp rdata 0, err 0;
//      load rsp_rdata 8'hA5; mem_W high exactly 1 cycle.
//   2. Load addr 3 after memory reset (mem holds i at address i) -> rsp_rdata 8'h03,
//      rsp_valid 2 cycles after accept.
//   3. Hold rsp_ready low 5 cycles on a load -> rsp_valid and rsp_rdata stable;
//      req_ready stays 0 throughout.
//   4. Fetch-add addr 7 (holds 8'hFF) addend 8'h02 with RMW_EN -> rsp_rdata 8'hFF,
//      later load returns 8'h01. Without RMW_EN -> rsp_err 1, mem unchanged.
//   5. Op 11 addr 2 -> rsp_err 1, rsp_rdata 0, mem_W never asserted, response after 1 cycle.
//   6. Assert rst in ACCESS of a store -> mem_W 0, target word unchanged,
//      all outputs 0, req_ready 1 in the first cycle after rst falls.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store front end placed directly in front of a single-port data memory.
// Accepts one core request at a time over a valid/ready handshake, sequences
// the memory address/write port, and returns load data or status over a
// valid/ready response channel. Optionally performs an atomic fetch-and-add.
//
// Configuration macro:
//   MEM_ACCESS_UNIT_RMW_EN  defined   -> op 2'b10 is fetch-and-add
//                           undefined -> op 2'b10 is handled as a reserved op
//
// Ports:
//   clk          in   1          single clock, all logic on posedge
//   rst          in   1          synchronous, active-high reset
//   req_valid    in   1          core request valid
//   req_ready    out  1          unit can accept a request (IDLE only)
//   req_op       in   2          00 load, 01 store, 10 fetch-add, 11 reserved
//   req_addr     in   ADDR_SIZE  word address
//   req_wdata    in   DATA_SIZE  store data / fetch-add addend
//   rsp_valid    out  1          response valid
//   rsp_ready    in   1          core accepts response
//   rsp_rdata    out  DATA_SIZE  load data / old value; 0 for store or error
//   rsp_err      out  1          request carried an unsupported op
//   mem_W        out  1          memory write enable
//   mem_DATA_WR  out  DATA_SIZE  memory write data
//   mem_ADDR     out  ADDR_SIZE  memory address (registered)
//   mem_DATA_RD  in   DATA_SIZE  memory read data, combinational from mem_ADDR
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_SIZE-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 mem_W,
    output logic [DATA_SIZE-1:0] mem_DATA_WR,
    output logic [ADDR_SIZE-1:0] mem_ADDR,
    input  logic [DATA_SIZE-1:0] mem_DATA_RD
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_FADD  = 2'b10;

    // RMW_WR only exists when fetch-and-add is built in; without it the
    // encoding 2'd2 is unused and falls into the default recovery arm.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
`ifdef MEM_ACCESS_UNIT_RMW_EN
        ST_RMW_WR = 2'd2,
`endif
        ST_RESP   = 2'd3
    } state_t;

    // Returns 1 for every op this build actually executes against memory.
    function automatic logic op_supported(input logic [1:0] op);
        logic ok;
        case (op)
            OP_LOAD:  ok = 1'b1;
            OP_STORE: ok = 1'b1;
`ifdef MEM_ACCESS_UNIT_RMW_EN
            OP_FADD:  ok = 1'b1;
`endif
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Registered state
    state_t                 state_r;
    logic [1:0]             op_r;
    logic [DATA_SIZE-1:0]   wdata_r;
    logic [ADDR_SIZE-1:0]   mem_addr_r;
    logic                   rsp_valid_r;
    logic [DATA_SIZE-1:0]   rsp_rdata_r;
    logic                   rsp_err_r;

    // Next-state values and combinational port drivers
    state_t                 state_s;
    logic [1:0]             op_s;
    logic [DATA_SIZE-1:0]   wdata_s;
    logic [ADDR_SIZE-1:0]   mem_addr_s;
    logic                   rsp_valid_s;
    logic [DATA_SIZE-1:0]   rsp_rdata_s;
    logic                   rsp_err_s;
    logic                   req_ready_s;
    logic                   mem_w_s;
    logic [DATA_SIZE-1:0]   mem_wdata_s;

    // State register and all datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            op_r        <= 2'b00;
            wdata_r     <= {DATA_SIZE{1'b0}};
            mem_addr_r  <= {ADDR_SIZE{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_SIZE{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            wdata_r     <= wdata_s;
            mem_addr_r  <= mem_addr_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
        end
    end

    // Next-state, next-register and port-strobe decode for the FSM.
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        wdata_s     = wdata_r;
        mem_addr_s  = mem_addr_r;
        rsp_valid_s = rsp_valid_r;
        rsp_rdata_s = rsp_rdata_r;
        rsp_err_s   = rsp_err_r;
        req_ready_s = 1'b0;
        mem_w_s     = 1'b0;
        mem_wdata_s = {DATA_SIZE{1'b0}};

        case (state_r)
            ST_IDLE: begin
                req_ready_s = 1'b1;
                if (req_valid) begin
                    op_s       = req_op;
                    wdata_s    = req_wdata;
                    mem_addr_s = req_addr;
                    if (op_supported(req_op)) begin
                        state_s = ST_ACCESS;
                    end else begin
                        // Unsupported op never touches memory: answer at once.
                        rsp_err_s   = 1'b1;
                        rsp_rdata_s = {DATA_SIZE{1'b0}};
                        rsp_valid_s = 1'b1;
                        state_s     = ST_RESP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                case (op_r)
                    OP_LOAD: begin
                        rsp_rdata_s = mem_DATA_RD;
                        rsp_valid_s = 1'b1;
                        state_s     = ST_RESP;
                    end
                    OP_STORE: begin
                        // Write strobe lasts exactly this one ACCESS cycle.
                        mem_w_s     = 1'b1;
                        mem_wdata_s = wdata_r;
                        rsp_rdata_s = {DATA_SIZE{1'b0}};
                        rsp_valid_s = 1'b1;
                        state_s     = ST_RESP;
                    end
`ifdef MEM_ACCESS_UNIT_RMW_EN
                    OP_FADD: begin
                        // Old value is captured here and reused as the adder
                        // operand in RMW_WR, so the read is not repeated.
                        rsp_rdata_s = mem_DATA_RD;
                        state_s     = ST_RMW_WR;
                    end
`endif
                    default: begin
                        rsp_err_s   = 1'b1;
                        rsp_rdata_s = {DATA_SIZE{1'b0}};
                        rsp_valid_s = 1'b1;
                        state_s     = ST_RESP;
                    end
                endcase
            end

`ifdef MEM_ACCESS_UNIT_RMW_EN
            ST_RMW_WR: begin
                // Sum is truncated to DATA_SIZE bits; carry out is dropped.
                mem_w_s     = 1'b1;
                mem_wdata_s = rsp_rdata_r + wdata_r;
                rsp_valid_s = 1'b1;
                state_s     = ST_RESP;
            end
`endif

            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    rsp_err_s   = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end

            default: begin
                rsp_valid_s = 1'b0;
                rsp_err_s   = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // Handshake ready and write strobe are forced low while reset is applied
    // so a write caught mid-flight never reaches the memory.
    assign req_ready   = req_ready_s & ~rst;
    assign mem_W       = mem_w_s & ~rst;
    assign mem_DATA_WR = rst ? {DATA_SIZE{1'b0}} : mem_wdata_s;
    assign mem_ADDR    = mem_addr_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_err     = rsp_err_r;

endmodule
